// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants, bus widths and FSM encoding for the fetch unit
//
// Purpose : common definitions imported by inst_fetch_unit and ifu_pc_reg.
// Contents: RstEnable, ZeroWord, InstAddrBus, InsBus, NOP_INST, ifu_state_e.
package inst_fetch_unit_pkg;

    // Level of rst that puts the unit into reset.
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Default address and instruction bus widths.
    localparam int          InstAddrBus = 32;
    localparam int          InsBus      = 32;

    // addi x0, x0, 0 -- presented whenever no live instruction is held.
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE  = 2'b00,
        IFU_ISSUE = 2'b01,
        IFU_WAIT  = 2'b10,
        IFU_HOLD  = 2'b11
    } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - program counter register with redirect / advance / hold priority
//
// Purpose : holds the fetch PC.
// Priority: reset > branch target (word aligned) > pc + PC_STEP on capture > hold.
// Ports   :
//   clk        in   core clock
//   rst        in   asynchronous active-high reset, loads RESET_PC
//   i_branch   in   redirect request
//   i_target   in   redirect address, bits [1:0] are cleared
//   i_capture  in   a fetched instruction was captured; advance sequentially
//   o_pc       out  current PC
module ifu_pc_reg
    import inst_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = InstAddrBus,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_branch,
    input  logic [ADDR_WIDTH-1:0] i_target,
    input  logic                  i_capture,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_branch) begin
            w_pc_next = i_target & ~ADDR_WIDTH'(3);
        end else if (i_capture) begin
            // Natural modulo-2^ADDR_WIDTH wrap.
            w_pc_next = r_pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage driving the IF/ID register
//
// Purpose : owns the PC, issues single-outstanding reads to instruction
//           memory, presents each instruction with its PC, holds under
//           stall and redirects on branch/jump from EX.
// Option  : IFU_FETCH_CNT_EN adds fetch_cnt_o, a count of accepted instructions.
// Ports   :
//   clk, rst                 clock, asynchronous active-high reset
//   stall_i                  IF/ID not accepting; presented output holds
//   branch_flag_i            one-cycle redirect request
//   branch_target_i          redirect address (bits [1:0] ignored)
//   imem_req_o, imem_addr_o  one-cycle read request and its address
//   imem_rvalid_i            read response strobe, one per request
//   imem_rdata_i             instruction word, valid with imem_rvalid_i
//   if_pc_o, if_inst_o       presented PC / instruction (NOP when invalid)
//   if_valid_o               presented instruction is live
//   fetch_cnt_o              (IFU_FETCH_CNT_EN only) accepted instruction count
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = InstAddrBus,
    parameter int                    INST_WIDTH = InsBus,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  branch_flag_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [INST_WIDTH-1:0] if_inst_o,
    output logic                  if_valid_o
`ifdef IFU_FETCH_CNT_EN
    ,
    output logic [31:0]           fetch_cnt_o
`endif
);

    localparam logic [INST_WIDTH-1:0] NOP_W = INST_WIDTH'(NOP_INST);

    ifu_state_e            r_state;
    ifu_state_e            w_state_next;
    logic                  r_kill;
    logic                  w_kill_next;
    logic [ADDR_WIDTH-1:0] r_if_pc;
    logic [ADDR_WIDTH-1:0] w_if_pc_next;
    logic [INST_WIDTH-1:0] r_if_inst;
    logic [INST_WIDTH-1:0] w_if_inst_next;
    logic                  r_if_valid;
    logic                  w_if_valid_next;
    logic                  w_req;
    logic                  w_capture;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pc;

    ifu_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (PC_STEP)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_branch   (branch_flag_i),
        .i_target   (branch_target_i),
        .i_capture  (w_capture),
        .o_pc       (w_pc)
    );

    // A live instruction only exists in HOLD, so accept is HOLD-qualified.
    assign w_accept = r_if_valid && !stall_i;

    always_comb begin
        w_state_next    = r_state;
        w_kill_next     = r_kill;
        w_if_pc_next    = r_if_pc;
        w_if_inst_next  = r_if_inst;
        w_if_valid_next = r_if_valid;
        w_req           = 1'b0;
        w_capture       = 1'b0;

        case (r_state)
            IFU_IDLE: begin
                w_state_next = IFU_ISSUE;
            end
            IFU_ISSUE: begin
                w_req        = 1'b1;
                w_state_next = IFU_WAIT;
            end
            IFU_WAIT: begin
                if (imem_rvalid_i) begin
                    if (r_kill || branch_flag_i) begin
                        w_kill_next  = 1'b0;
                        w_state_next = IFU_ISSUE;
                    end else begin
                        w_capture       = 1'b1;
                        w_if_pc_next    = w_pc;
                        w_if_inst_next  = imem_rdata_i;
                        w_if_valid_next = 1'b1;
                        w_state_next    = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                // The next request goes out in the accept cycle itself,
                // giving one instruction every two cycles.
                if (w_accept) begin
                    w_req           = 1'b1;
                    w_if_valid_next = 1'b0;
                    w_if_inst_next  = NOP_W;
                    w_state_next    = IFU_WAIT;
                end
            end
            default: begin
                w_state_next = IFU_IDLE;
            end
        endcase

        // Redirect overrides stall and response. A request that is in
        // flight (or leaving this cycle) must have its response dropped,
        // so wait it out with kill set before issuing at the target.
        if (branch_flag_i && (r_state != IFU_IDLE)) begin
            w_if_valid_next = 1'b0;
            w_if_inst_next  = NOP_W;
            if (r_state == IFU_WAIT) begin
                if (!imem_rvalid_i) begin
                    w_kill_next  = 1'b1;
                    w_state_next = IFU_WAIT;
                end
            end else if (w_req) begin
                w_kill_next  = 1'b1;
                w_state_next = IFU_WAIT;
            end else begin
                w_state_next = IFU_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_kill     <= 1'b0;
            r_if_pc    <= ADDR_WIDTH'(ZeroWord);
            r_if_inst  <= NOP_W;
            r_if_valid <= 1'b0;
        end else begin
            r_kill     <= w_kill_next;
            r_if_pc    <= w_if_pc_next;
            r_if_inst  <= w_if_inst_next;
            r_if_valid <= w_if_valid_next;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_req ? w_pc : '0;
    assign if_pc_o     = r_if_pc;
    assign if_inst_o   = r_if_inst;
    assign if_valid_o  = r_if_valid;

`ifdef IFU_FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    // An instruction flushed by a same-cycle redirect does not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_fetch_cnt <= ZeroWord;
        end else if (w_accept && !branch_flag_i) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_valid;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = '0;
`ifdef IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] w_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic        wreq_seen = 1'b0;
    logic [31:0] wa = '0;

    always #5 clk = ~clk;

    inst_fetch_unit u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o)
`ifdef IFU_FETCH_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o)
`endif
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (w_zero),
        .branch_flag_i   (w_zero),
        .branch_target_i (w_zero32),
        .imem_req_o      (w_req),
        .imem_addr_o     (w_addr),
        .imem_rvalid_i   (w_rvalid),
        .imem_rdata_i    (w_rdata),
        .if_pc_o         (w_pc),
        .if_inst_o       (w_inst),
        .if_valid_o      (w_valid)
`ifdef IFU_FETCH_CNT_EN
        ,
        .fetch_cnt_o     (w_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory with configurable latency; requests are seen mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req_o) begin
                check_eq("one_outstanding", {31'd0, pend}, 32'd0);
                pend  = 1;
                cnt   = mem_lat;
                paddr = imem_addr_o;
            end
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(paddr);
                    pend          = 0;
                end
            end
        end
    end

    // One-cycle memory for the wrap instance.
    initial begin
        forever begin
            @(negedge clk);
            wreq_seen = w_req;
            wa        = w_addr;
            @(posedge clk);
            #1;
            w_rvalid = wreq_seen && !rst;
            w_rdata  = mem_word(wa);
        end
    end

    task automatic do_reset(input int lat);
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        mem_lat         = lat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
        @(negedge clk);
    endtask

    task automatic adv(input logic st, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        cyc++;
        stall_i         = st;
        branch_flag_i   = br;
        branch_target_i = tgt;
        @(negedge clk);
    endtask

    task automatic expect_out(input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
        string t;
        t = $sformatf("c%0d", cyc);
        check_eq({t, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
        if (req) check_eq({t, ".addr"}, imem_addr_o, addr);
        check_eq({t, ".valid"}, {31'd0, if_valid_o}, {31'd0, vld});
        if (vld) begin
            check_eq({t, ".pc"}, if_pc_o, pc);
            check_eq({t, ".inst"}, if_inst_o, mem_word(pc));
        end else begin
            check_eq({t, ".nop"}, if_inst_o, NOP);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int acc;
        int guard;

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.req", {31'd0, imem_req_o}, 32'd0);
        check_eq("rst.addr", imem_addr_o, 32'd0);
        check_eq("rst.valid", {31'd0, if_valid_o}, 32'd0);
        check_eq("rst.pc", if_pc_o, 32'd0);
        check_eq("rst.inst", if_inst_o, NOP);

        // Free run, 1-cycle memory: requests on cycles 2, 4, 6.
        do_reset(1);
        expect_out(0, 0, 0, 0);
        adv(0, 0, 0); expect_out(1, 32'h0, 0, 0);
        check_eq("wrap.c2.req", {31'd0, w_req}, 32'd1);
        check_eq("wrap.c2.addr", w_addr, 32'hFFFF_FFFC);
        adv(0, 0, 0); expect_out(0, 0, 0, 0);
        adv(0, 0, 0); expect_out(1, 32'h4, 1, 32'h0);
        check_eq("wrap.c4.addr", w_addr, 32'h0000_0000);
        check_eq("wrap.c4.pc", w_pc, 32'hFFFF_FFFC);
        check_eq("wrap.c4.inst", w_inst, mem_word(32'hFFFF_FFFC));
        adv(0, 0, 0); expect_out(0, 0, 0, 0);
        adv(0, 0, 0); expect_out(1, 32'h8, 1, 32'h4);
        adv(0, 0, 0); expect_out(0, 0, 0, 0);
        check_eq("pre_arst.pc", if_pc_o, 32'h4);
        // Asynchronous reset in the middle of WAIT.
        #1 rst = 1'b1;
        #1;
        check_eq("arst.req", {31'd0, imem_req_o}, 32'd0);
        check_eq("arst.addr", imem_addr_o, 32'd0);
        check_eq("arst.valid", {31'd0, if_valid_o}, 32'd0);
        check_eq("arst.pc", if_pc_o, 32'd0);
        check_eq("arst.inst", if_inst_o, NOP);
        check_eq("arst.wrap_pc", w_pc, 32'd0);

        // Stall for 5 cycles with pc 0x4 presented; release issues 0x8 at once.
        do_reset(1);
        repeat (4) adv(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            adv(1, 0, 0);
            expect_out(0, 0, 1, 32'h4);
        end
        adv(0, 0, 0); expect_out(1, 32'h8, 1, 32'h4);
        adv(0, 0, 0); expect_out(0, 0, 0, 0);
        adv(0, 0, 0); expect_out(1, 32'hC, 1, 32'h8);

        // Branch in WAIT with 3-cycle memory; target 0x103 aligns to 0x100.
        do_reset(3);
        adv(0, 0, 0);          expect_out(1, 32'h0, 0, 0);
        adv(0, 1, 32'h103);    expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(1, 32'h100, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(1, 32'h104, 1, 32'h100);

        // Branch with rvalid in the same cycle, then branch while stalled in HOLD.
        do_reset(1);
        adv(0, 0, 0);          expect_out(1, 32'h0, 0, 0);
        adv(0, 1, 32'h200);    expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(1, 32'h200, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(1, 0, 0);          expect_out(0, 0, 1, 32'h200);
        adv(1, 1, 32'h300);    expect_out(0, 0, 1, 32'h200);
        adv(0, 0, 0);          expect_out(1, 32'h300, 0, 0);
        adv(0, 0, 0);          expect_out(0, 0, 0, 0);
        adv(0, 0, 0);          expect_out(1, 32'h304, 1, 32'h300);

`ifdef IFU_FETCH_CNT_EN
        // 10 accepted instructions; fetches flushed by redirects on cycles 3 and 9.
        do_reset(1);
        check_eq("cnt.rst", fetch_cnt_o, 32'd0);
        acc   = 0;
        guard = 0;
        while (acc < 10 && guard < 100) begin
            if (cyc + 1 == 3)      adv(0, 1, 32'h400);
            else if (cyc + 1 == 9) adv(0, 1, 32'h500);
            else                   adv(0, 0, 0);
            if (if_valid_o && !stall_i && !branch_flag_i) acc++;
            guard++;
        end
        check_eq("cnt.budget", {31'd0, guard < 100}, 32'd1);
        adv(0, 0, 0);
        check_eq("cnt.final", fetch_cnt_o, 32'd10);
        #1 rst = 1'b1;
        #1;
        check_eq("cnt.arst", fetch_cnt_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
